// File: rtl/wca_lime_tx_serializer_pkg.sv
// Shared Lime definitions: FSM state encoding, bus widths and loopback test-pattern words.
// Used by the TX serializer and reusable by the receive path.
package wca_lime_pkg;

  localparam int unsigned LIME_WORD_W = 12;
  localparam int unsigned IQ_W        = 24;

  localparam logic [LIME_WORD_W-1:0] TEST_PAT_I = 12'h17F;
  localparam logic [LIME_WORD_W-1:0] TEST_PAT_Q = 12'hF81;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_IPH,
    ST_QPH
  } tx_state_t;

  typedef struct packed {
    logic [LIME_WORD_W-1:0] i;
    logic [LIME_WORD_W-1:0] q;
  } iq_sample_t;

endpackage

// File: rtl/wca_lime_tx_serializer_if.sv
// Sample input strobe and Lime TX pin bundle for the TX serializer.
interface wca_lime_tx_serializer_if;
  import wca_lime_pkg::*;

  logic                   dstrobe_in;
  logic [IQ_W-1:0]        tx_iq;
  logic                   sample_req;
  logic [LIME_WORD_W-1:0] rf_txdata;
  logic                   rf_txiqsel;
  logic                   rf_txen;

  modport master (
    output dstrobe_in, tx_iq,
    input  sample_req, rf_txdata, rf_txiqsel, rf_txen
  );

  modport slave (
    input  dstrobe_in, tx_iq,
    output sample_req, rf_txdata, rf_txiqsel, rf_txen
  );

endinterface

// File: rtl/wca_lime_tx_serializer_fifo.sv
// Synchronous first-word-fall-through FIFO; push while full succeeds only with a concurrent pop.
module wca_sync_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 24,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign rdata = mem[rptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wca_lime_tx_serializer.sv
// Buffers 24-bit IQ samples and serialises them as I then Q words on the Lime 12-bit TX bus.
// Optional macro WCA_LIME_TX_TEST_PATTERN_EN adds test_mode (fixed 17F/F81 loopback words).
module wca_lime_tx_serializer
  import wca_lime_pkg::*;
#(
  parameter  int unsigned FIFO_DEPTH  = 4,
  parameter  int unsigned WORD_CYCLES = 2,
  localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     aclr,
`ifdef WCA_LIME_TX_TEST_PATTERN_EN
  input  logic                     test_mode,
`endif
  wca_lime_tx_serializer_if.slave  bus,
  output logic                     underflow,
  output logic                     overflow,
  output logic [LVL_W-1:0]         fifo_level
);

  localparam int unsigned CW = (WORD_CYCLES > 1) ? $clog2(WORD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WORD_CYCLES - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (WORD_CYCLES < 1) begin : g_bad_word
    $error("WORD_CYCLES must be at least 1");
  end

  tx_state_t              state;
  tx_state_t              state_nxt;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nxt;
  logic                   word_last;
  logic                   pop_req;
  iq_sample_t             hold;
  logic [IQ_W-1:0]        fifo_rdata;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push_drop;
  logic [LIME_WORD_W-1:0] txdata;
  logic                   txiqsel;
  logic                   txen;

  wca_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IQ_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clr   (aclr),
    .push  (bus.dstrobe_in),
    .pop   (pop_req),
    .wdata (bus.tx_iq),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign word_last = (cnt == LAST_CNT);
  assign push_drop = bus.dstrobe_in && fifo_full && !pop_req;

  always_ff @(posedge clock) begin
    if (reset || aclr) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The next sample is popped on the final Q cycle so IPH follows QPH with no gap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop_req   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (enable) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        pop_req   = 1'b1;
        cnt_nxt   = '0;
        state_nxt = ST_IPH;
      end
      ST_IPH: begin
        if (word_last) begin
          cnt_nxt   = '0;
          state_nxt = ST_QPH;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_QPH: begin
        if (word_last) begin
          cnt_nxt = '0;
          if (enable) begin
            pop_req   = 1'b1;
            state_nxt = ST_IPH;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    txdata  = '0;
    txiqsel = 1'b0;
    txen    = (state != ST_IDLE);
    case (state)
      ST_IPH: begin
        txiqsel = 1'b1;
`ifdef WCA_LIME_TX_TEST_PATTERN_EN
        txdata  = test_mode ? TEST_PAT_I : hold.i;
`else
        txdata  = hold.i;
`endif
      end
      ST_QPH: begin
`ifdef WCA_LIME_TX_TEST_PATTERN_EN
        txdata  = test_mode ? TEST_PAT_Q : hold.q;
`else
        txdata  = hold.q;
`endif
      end
      default: begin
        txdata  = '0;
        txiqsel = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || aclr) begin
      hold      <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (pop_req) begin
        if (fifo_empty) begin
          hold <= '0;
`ifdef WCA_LIME_TX_TEST_PATTERN_EN
          if (!test_mode) underflow <= 1'b1;
`else
          underflow <= 1'b1;
`endif
        end else begin
          hold <= fifo_rdata;
        end
      end
      if (push_drop) overflow <= 1'b1;
    end
  end

  assign bus.sample_req = pop_req;
  assign bus.rf_txdata  = txdata;
  assign bus.rf_txiqsel = txiqsel;
  assign bus.rf_txen    = txen;

endmodule

// File: tb/tb_wca_lime_tx_serializer.sv
// Directed bench for wca_lime_tx_serializer (FIFO_DEPTH=4, WORD_CYCLES=2).
// Define WCA_LIME_TX_TEST_PATTERN_EN to include the test-pattern scenario.
module tb_wca_lime_tx_serializer;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       aclr;
`ifdef WCA_LIME_TX_TEST_PATTERN_EN
  logic       test_mode;
`endif
  logic       underflow;
  logic       overflow;
  logic [2:0] fifo_level;

  int total = 0;
  int bad   = 0;

  wca_lime_tx_serializer_if bus ();

  wca_lime_tx_serializer #(
    .FIFO_DEPTH  (4),
    .WORD_CYCLES (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .aclr       (aclr),
`ifdef WCA_LIME_TX_TEST_PATTERN_EN
    .test_mode  (test_mode),
`endif
    .bus        (bus),
    .underflow  (underflow),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset          = 1'b1;
    enable         = 1'b0;
    aclr           = 1'b0;
    bus.dstrobe_in = 1'b0;
    bus.tx_iq      = '0;
`ifdef WCA_LIME_TX_TEST_PATTERN_EN
    test_mode      = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [23:0] s);
    bus.dstrobe_in = 1'b1;
    bus.tx_iq      = s;
    tick();
    bus.dstrobe_in = 1'b0;
  endtask

  task automatic wait_idle;
    for (int k = 0; k < 20 && bus.rf_txen !== 1'b0; k++) tick();
    total++;
    if (bus.rf_txen !== 1'b0) begin
      bad++;
      $display("FAIL idle_timeout: rf_txen=%b want 0", bus.rf_txen);
    end
  endtask

  task automatic test_reset;
    do_reset();
    total += 7;
    if (bus.rf_txdata !== 12'h000) begin bad++; $display("FAIL reset_txdata: got %h want 000", bus.rf_txdata); end
    if (bus.rf_txiqsel !== 1'b0) begin bad++; $display("FAIL reset_iqsel: got %b want 0", bus.rf_txiqsel); end
    if (bus.rf_txen !== 1'b0) begin bad++; $display("FAIL reset_txen: got %b want 0", bus.rf_txen); end
    if (bus.sample_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", bus.sample_req); end
    if (underflow !== 1'b0) begin bad++; $display("FAIL reset_underflow: got %b want 0", underflow); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_basic;
    logic [11:0] exp_d [8] = '{12'h123, 12'h123, 12'hABC, 12'hABC, 12'h7FF, 12'h7FF, 12'h800, 12'h800};
    logic        exp_s [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    push(24'h123ABC);
    push(24'h7FF800);
    enable = 1'b1;
    tick();
    total += 3;
    if (bus.rf_txen !== 1'b1) begin bad++; $display("FAIL basic_load_txen: got %b want 1", bus.rf_txen); end
    if (bus.sample_req !== 1'b1) begin bad++; $display("FAIL basic_load_req: got %b want 1", bus.sample_req); end
    if (bus.rf_txiqsel !== 1'b0) begin bad++; $display("FAIL basic_load_iqsel: got %b want 0", bus.rf_txiqsel); end
    tick();
    for (int i = 0; i < 8; i++) begin
      total += 4;
      if (bus.rf_txdata !== exp_d[i]) begin bad++; $display("FAIL basic_data[%0d]: got %h want %h", i, bus.rf_txdata, exp_d[i]); end
      if (bus.rf_txiqsel !== exp_s[i]) begin bad++; $display("FAIL basic_iqsel[%0d]: got %b want %b", i, bus.rf_txiqsel, exp_s[i]); end
      if (bus.rf_txen !== 1'b1) begin bad++; $display("FAIL basic_txen[%0d]: got %b want 1", i, bus.rf_txen); end
      if (bus.sample_req !== (i == 3)) begin bad++; $display("FAIL basic_req[%0d]: got %b want %b", i, bus.sample_req, (i == 3)); end
      if (i == 6) enable = 1'b0;
      tick();
    end
    total += 3;
    if (bus.rf_txen !== 1'b0) begin bad++; $display("FAIL basic_end_txen: got %b want 0", bus.rf_txen); end
    if (underflow !== 1'b0) begin bad++; $display("FAIL basic_underflow: got %b want 0", underflow); end
    if (fifo_level !== 3'd0) begin bad++; $display("FAIL basic_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_underflow;
    do_reset();
    enable = 1'b1;
    tick();
    total++;
    if (bus.sample_req !== 1'b1) begin bad++; $display("FAIL uf_load_req: got %b want 1", bus.sample_req); end
    tick();
    total++;
    if (underflow !== 1'b1) begin bad++; $display("FAIL uf_flag: got %b want 1", underflow); end
    for (int i = 0; i < 8; i++) begin
      total += 3;
      if (bus.rf_txdata !== 12'h000) begin bad++; $display("FAIL uf_data[%0d]: got %h want 000", i, bus.rf_txdata); end
      if (bus.rf_txiqsel !== ((i % 4) < 2)) begin bad++; $display("FAIL uf_iqsel[%0d]: got %b want %b", i, bus.rf_txiqsel, ((i % 4) < 2)); end
      if (bus.sample_req !== ((i % 4) == 3)) begin bad++; $display("FAIL uf_req[%0d]: got %b want %b", i, bus.sample_req, ((i % 4) == 3)); end
      tick();
    end
    enable = 1'b0;
    wait_idle();
    total++;
    if (underflow !== 1'b1) begin bad++; $display("FAIL uf_sticky: got %b want 1", underflow); end
  endtask

  task automatic test_overflow;
    logic [23:0] s [6] = '{24'h001002, 24'h003004, 24'h005006, 24'h007008, 24'h00900A, 24'h00B00C};
    logic [23:0] cur;
    logic [11:0] exp;
    do_reset();
    for (int k = 0; k < 6; k++) push(s[k]);
    total += 2;
    if (fifo_level !== 3'd4) begin bad++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    enable = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 16; i++) begin
      cur = s[i / 4];
      exp = ((i % 4) < 2) ? cur[23:12] : cur[11:0];
      total++;
      if (bus.rf_txdata !== exp) begin bad++; $display("FAIL ovf_data[%0d]: got %h want %h", i, bus.rf_txdata, exp); end
      if (i == 13) enable = 1'b0;
      tick();
    end
    total += 3;
    if (bus.rf_txen !== 1'b0) begin bad++; $display("FAIL ovf_end_txen: got %b want 0", bus.rf_txen); end
    if (underflow !== 1'b0) begin bad++; $display("FAIL ovf_underflow: got %b want 0", underflow); end
    if (fifo_level !== 3'd0) begin bad++; $display("FAIL ovf_end_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_full_push_pop;
    do_reset();
    push(24'h111111);
    push(24'h222222);
    push(24'h333333);
    push(24'h444444);
    enable = 1'b1;
    tick();
    for (int c = 0; c < 12; c++) begin
      bus.dstrobe_in = bus.sample_req;
      bus.tx_iq      = 24'h555555;
      tick();
      total += 2;
      if (fifo_level !== 3'd4) begin bad++; $display("FAIL fpp_level[%0d]: got %0d want 4", c, fifo_level); end
      if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_overflow[%0d]: got %b want 0", c, overflow); end
      if (c == 0) begin
        total++;
        if (bus.rf_txdata !== 12'h111) begin bad++; $display("FAIL fpp_first_i: got %h want 111", bus.rf_txdata); end
      end
    end
    bus.dstrobe_in = 1'b0;
    enable = 1'b0;
    wait_idle();
  endtask

  task automatic test_enable_drop_aclr;
    logic [11:0] exp_d [4] = '{12'hABC, 12'hABC, 12'h123, 12'h123};
    do_reset();
    push(24'hABC123);
    push(24'h456DEF);
    enable = 1'b1;
    tick();
    tick();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total += 3;
      if (bus.rf_txdata !== exp_d[i]) begin bad++; $display("FAIL drop_data[%0d]: got %h want %h", i, bus.rf_txdata, exp_d[i]); end
      if (bus.rf_txiqsel !== (i < 2)) begin bad++; $display("FAIL drop_iqsel[%0d]: got %b want %b", i, bus.rf_txiqsel, (i < 2)); end
      if (bus.rf_txen !== 1'b1) begin bad++; $display("FAIL drop_txen[%0d]: got %b want 1", i, bus.rf_txen); end
      tick();
    end
    total += 3;
    if (bus.rf_txen !== 1'b0) begin bad++; $display("FAIL drop_idle_txen: got %b want 0", bus.rf_txen); end
    if (bus.rf_txdata !== 12'h000) begin bad++; $display("FAIL drop_idle_data: got %h want 000", bus.rf_txdata); end
    if (fifo_level !== 3'd1) begin bad++; $display("FAIL drop_level: got %0d want 1", fifo_level); end
    push(24'h0C0C0C);
    push(24'h0D0D0D);
    push(24'h0E0E0E);
    push(24'h0F0F0F);
    total += 2;
    if (fifo_level !== 3'd4) begin bad++; $display("FAIL aclr_pre_level: got %0d want 4", fifo_level); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL aclr_pre_overflow: got %b want 1", overflow); end
    enable = 1'b1;
    tick();
    tick();
    total++;
    if (bus.rf_txdata !== 12'h456) begin bad++; $display("FAIL aclr_pre_data: got %h want 456", bus.rf_txdata); end
    aclr = 1'b1;
    tick();
    total += 5;
    if (bus.rf_txen !== 1'b0) begin bad++; $display("FAIL aclr_txen: got %b want 0", bus.rf_txen); end
    if (bus.rf_txdata !== 12'h000) begin bad++; $display("FAIL aclr_data: got %h want 000", bus.rf_txdata); end
    if (bus.rf_txiqsel !== 1'b0) begin bad++; $display("FAIL aclr_iqsel: got %b want 0", bus.rf_txiqsel); end
    if (fifo_level !== 3'd0) begin bad++; $display("FAIL aclr_level: got %0d want 0", fifo_level); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL aclr_overflow: got %b want 0", overflow); end
    aclr   = 1'b0;
    enable = 1'b0;
    tick();
    total++;
    if (bus.rf_txen !== 1'b0) begin bad++; $display("FAIL aclr_after_txen: got %b want 0", bus.rf_txen); end
  endtask

`ifdef WCA_LIME_TX_TEST_PATTERN_EN
  task automatic test_pattern;
    logic [11:0] exp;
    do_reset();
    push(24'h123456);
    push(24'h789ABC);
    test_mode = 1'b1;
    enable    = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      exp = ((i % 4) < 2) ? 12'h17F : 12'hF81;
      total += 2;
      if (bus.rf_txdata !== exp) begin bad++; $display("FAIL pat_data[%0d]: got %h want %h", i, bus.rf_txdata, exp); end
      if (bus.rf_txiqsel !== ((i % 4) < 2)) begin bad++; $display("FAIL pat_iqsel[%0d]: got %b want %b", i, bus.rf_txiqsel, ((i % 4) < 2)); end
      tick();
    end
    total += 2;
    if (underflow !== 1'b0) begin bad++; $display("FAIL pat_underflow: got %b want 0", underflow); end
    if (fifo_level !== 3'd0) begin bad++; $display("FAIL pat_level: got %0d want 0", fifo_level); end
    enable = 1'b0;
    wait_idle();
    test_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_overflow();
    test_full_push_pop();
    test_enable_drop_aclr();
`ifdef WCA_LIME_TX_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wca_lime_tx_serializer.md
Name: wca_lime_tx_serializer

Overview:
Transmit-side counterpart of the Lime receive path. It accepts 24-bit packed IQ samples from the DSP chain (up-converter output) on a strobe and buffers them in a small FIFO. Each sample is serialised onto the Lime 12-bit TX bus as an I word followed by a Q word, with the TXIQSEL framing the Lime part expects. It sits between the DSP up-converter and the Lime RF TX pins, in the DSP clock domain.

Parameters:
FIFO_DEPTH, 4, sample FIFO depth; power of two, minimum 2
WORD_CYCLES, 2, clock cycles each 12-bit word is held on rf_txdata; minimum 1

Ports:
clock  in  1  DSP clock; all logic on rising edge
reset  in  1  synchronous, active-high
enable  in  1  serializer run control
aclr  in  1  synchronous clear of FIFO and sticky flags; also active-high
dstrobe_in  in  1  one-cycle strobe; tx_iq is valid this cycle
tx_iq  in  24  {I[23:12], Q[11:0]}, two's complement
sample_req  out  1  one-cycle pulse when a sample is popped; the upstream block uses it as pacing
rf_txdata  out  12  Lime TX word
rf_txiqsel  out  1  1 = I word, 0 = Q word
rf_txen  out  1  Lime TX enable
underflow  out  1  sticky; set when an output sample had to be zero-filled
overflow  out  1  sticky; set when an input sample was dropped
fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (or aclr): FIFO empty; fifo_level=0; rf_txdata=0; rf_txiqsel=0; rf_txen=0; sample_req=0; underflow=0; overflow=0; state=IDLE.
- Reset takes priority over aclr. aclr takes priority over every other event in the same cycle. Both abort mid-word immediately.
- FIFO write: dstrobe_in=1 and not full -> push tx_iq. This happens regardless of enable, so the FIFO can be prefilled. Push while full -> sample dropped, overflow<=1.
- Simultaneous push and pop while full: both take effect; nothing is dropped; level is unchanged.
- States:
  - IDLE: rf_txen=0, rf_txdata=0, rf_txiqsel=0. On enable=1 go to LOAD.
  - LOAD: one cycle; pops the head sample if present.
  - IPH: rf_txdata=I, rf_txiqsel=1; held WORD_CYCLES cycles.
  - QPH: rf_txdata=Q, rf_txiqsel=0; held WORD_CYCLES cycles.
  - Transitions: QPH end with enable=1 -> IPH directly, with the next sample popped on the last QPH cycle. QPH end with enable=0 -> IDLE.
- LOAD exists only on the enable rising edge. Steady state is seamless: exactly 2*WORD_CYCLES clocks per sample.
- Enable dropping mid-sample: the current I/Q pair completes; the bus never ends on a lone I word.
- Pop: registered sample into an output holding register; sample_req pulses in the pop cycle.
- Empty at a pop point: I=Q=0 is transmitted, underflow<=1, sample_req still pulses, and framing continues.
- rf_txen=1 in every cycle of LOAD, IPH and QPH. It drops in the cycle IDLE is entered.
- Latency: enable rises at cycle n -> LOAD at n+1 -> rf_txen=1, rf_txiqsel=1 with the I word at n+2.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_level saturates naturally at FIFO_DEPTH.

Optional Feature:
WCA_LIME_TX_TEST_PATTERN_EN
- Defined: extra input port test_mode (1 bit). While test_mode=1, IPH outputs 12'h17F and QPH outputs 12'hF81 instead of FIFO data. The FIFO is still popped, and no underflow is flagged. This matches the receive-side loopback pattern.
- Undefined: no port and no logic; the data path is always FIFO data.

Decomposition:
- Shared package wca_lime_pkg holds:
  - state encoding (IDLE, LOAD, IPH, QPH)
  - LIME_WORD_W=12 and IQ_W=24
  - the test-pattern constants 12'h17F and 12'hF81
- One natural sub-module: wca_sync_fifo (parameterised depth/width). It provides push, pop, full, empty and level, and is reusable by the receive path.

Test Plan:
1. Basic serialisation: prefill 24'h123ABC, then 24'h7FF800; enable=1 (WORD_CYCLES=2) -> rf_txdata sequence 123,123,ABC,ABC,7FF,7FF,800,800 with rf_txiqsel 1,1,0,0,1,1,0,0; the first I word appears 2 cycles after enable.
2. Underflow: enable with an empty FIFO -> rf_txdata=0 with correct iqsel toggling; underflow=1 after the first pop; sample_req pulses every 4 cycles.
3. Overflow: 6 strobes with enable=0 (FIFO_DEPTH=4) -> fifo_level=4, overflow=1; the first four samples are transmitted in order after enable.
4. Full push+pop: hold the FIFO full with dstrobe_in coincident with sample_req -> overflow stays 0 and fifo_level stays 4.
5. Enable drop mid-I-word -> the Q word completes, then IDLE; rf_txen=0 the following cycle. aclr mid-sample -> immediate IDLE, FIFO empty, flags cleared.
6. Test pattern (macro on, test_mode=1) -> alternating 17F/F81 on rf_txdata; the FIFO drains; underflow=0.
